// File: rtl/eeprom_cfg_loader.sv
// Boot-time configuration loader: reads EEPROM page 0, validates magic byte and XOR checksum
// with bounded retries, then publishes node id / flags, or defaults plus an error flag.
module eeprom_cfg_loader #(
    parameter int unsigned INIT_WAIT_CYCLES = 10000000,
    parameter int unsigned TIMEOUT_CYCLES   = 200000,
    parameter int unsigned RETRY_GAP_CYCLES = 20000,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter logic [7:0]  CFG_MAGIC        = 8'h5A,
    parameter logic [7:0]  DEFAULT_NODE_ID  = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_reload,
    input  logic        i_eeprom_busy,
    input  logic        i_eeprom_done,
    input  logic [63:0] i_page,
    output logic        o_eeprom_start,
    output logic [7:0]  o_node_id,
    output logic [7:0]  o_cfg_flags,
    output logic        o_cfg_valid,
    output logic        o_cfg_error,
    output logic        o_loading,
    output logic [3:0]  o_attempt
);

    localparam logic [2:0] S_INIT_WAIT  = 3'd0;
    localparam logic [2:0] S_START      = 3'd1;
    localparam logic [2:0] S_WAIT_DONE  = 3'd2;
    localparam logic [2:0] S_CHECK      = 3'd3;
    localparam logic [2:0] S_RETRY_WAIT = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;
    localparam logic [2:0] S_FAIL       = 3'd6;

    logic [2:0]  state;
    logic [31:0] cnt;
    logic [4:0]  attempt_cnt;
    logic [63:0] page;
    logic [7:0]  page_xor;
    logic        page_ok;
    logic        retry_ok;

    always_comb begin
        page_xor = 8'h00;
        for (int n = 0; n < 8; n++) begin
            page_xor = page_xor ^ page[8*n +: 8];
        end
    end

    assign page_ok  = (page[55:48] == CFG_MAGIC) && (page_xor == 8'h00);
    assign retry_ok = ({27'd0, attempt_cnt} <= MAX_RETRIES);

    assign o_eeprom_start = (state == S_START) && !i_eeprom_busy;
    assign o_loading      = (state == S_START) || (state == S_WAIT_DONE) ||
                            (state == S_CHECK) || (state == S_RETRY_WAIT);

    // Five count bits let MAX_RETRIES=15 reach its 16th attempt; the port saturates at 15.
    assign o_attempt = attempt_cnt[4] ? 4'hF : attempt_cnt[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_INIT_WAIT;
            cnt         <= '0;
            attempt_cnt <= '0;
            page        <= '0;
            o_node_id   <= DEFAULT_NODE_ID;
            o_cfg_flags <= 8'h00;
            o_cfg_valid <= 1'b0;
            o_cfg_error <= 1'b0;
        end else begin
            case (state)
                S_INIT_WAIT: begin
                    if (cnt + 32'd1 >= INIT_WAIT_CYCLES) begin
                        cnt   <= '0;
                        state <= S_START;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_START: begin
                    if (!i_eeprom_busy) begin
                        attempt_cnt <= attempt_cnt + 5'd1;
                        cnt         <= '0;
                        state       <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    // A completion arriving in the expiry cycle still counts.
                    if (i_eeprom_done) begin
                        page  <= i_page;
                        state <= S_CHECK;
                    end else if (cnt + 32'd1 >= TIMEOUT_CYCLES) begin
                        cnt <= '0;
                        if (retry_ok) begin
                            state <= S_RETRY_WAIT;
                        end else begin
                            state       <= S_FAIL;
                            o_node_id   <= DEFAULT_NODE_ID;
                            o_cfg_flags <= 8'h00;
                            o_cfg_valid <= 1'b0;
                            o_cfg_error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_CHECK: begin
                    cnt <= '0;
                    if (page_ok) begin
                        o_node_id   <= page[7:0];
                        o_cfg_flags <= page[15:8];
                        o_cfg_valid <= 1'b1;
                        o_cfg_error <= 1'b0;
                        state       <= S_DONE;
                    end else if (retry_ok) begin
                        state <= S_RETRY_WAIT;
                    end else begin
                        state       <= S_FAIL;
                        o_node_id   <= DEFAULT_NODE_ID;
                        o_cfg_flags <= 8'h00;
                        o_cfg_valid <= 1'b0;
                        o_cfg_error <= 1'b1;
                    end
                end
                S_RETRY_WAIT: begin
                    if (cnt + 32'd1 >= RETRY_GAP_CYCLES) begin
                        cnt   <= '0;
                        state <= S_START;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DONE, S_FAIL: begin
                    // Reload keeps the last published id/flags visible while re-reading.
                    if (i_reload) begin
                        o_cfg_valid <= 1'b0;
                        o_cfg_error <= 1'b0;
                        attempt_cnt <= '0;
                        cnt         <= '0;
                        state       <= S_START;
                    end
                end
                default: begin
                    state <= S_INIT_WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_cfg_loader.sv
// Self-checking bench for eeprom_cfg_loader: table vectors, randomized EEPROM behaviour against a
// cycle-level event model, and hand sequences for reload, spurious done and mid-load reset.
module tb_eeprom_cfg_loader;

    localparam int INIT    = 10;
    localparam int TIMEOUT = 50;
    localparam int GAP     = 5;
    localparam int MAXR    = 2;
    localparam logic [7:0]  MAGIC       = 8'h5A;
    localparam logic [63:0] PAGE_GOOD   = 64'h4E5A_0000_0000_0317;
    localparam logic [63:0] PAGE_BADSUM = 64'h005A_0000_0000_0317;
    localparam logic [63:0] PAGE_22     = 64'h7B5A_0000_0000_0322;

    typedef struct {
        int              busy_hold;
        logic [3:0][7:0]  delay;
        logic [3:0][63:0] pages;
        logic [3:0]       good;
        bit              hand;
        int              exp_first_off;
        int              exp_nstarts;
        logic [7:0]      exp_node;
        logic [7:0]      exp_flags;
        logic            exp_valid;
        logic            exp_error;
        logic [3:0]      exp_attempt;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        i_reload;
    logic        i_eeprom_busy;
    logic        i_eeprom_done;
    logic [63:0] i_page;
    logic        o_eeprom_start;
    logic [7:0]  o_node_id;
    logic [7:0]  o_cfg_flags;
    logic        o_cfg_valid;
    logic        o_cfg_error;
    logic        o_loading;
    logic [3:0]  o_attempt;

    int checks;
    int errors;
    int cyc;
    int busy_hi;
    int done_at;
    int spur_at;
    logic [63:0] done_page;
    logic [63:0] spur_page;
    logic [3:0][7:0]  cur_delay;
    logic [3:0][63:0] cur_page;
    int att_idx;
    int mon_idx;
    int start_q[$];
    int first_valid;
    int first_err;
    int consec_err;
    logic prev_start;

    int m_starts[$];
    int m_valid_cyc;
    int m_err_cyc;
    logic [7:0] m_node;
    logic [7:0] m_flags;
    logic m_valid;
    logic m_err;
    int m_attempt;

    vec_t vecs[5];

    eeprom_cfg_loader #(
        .INIT_WAIT_CYCLES(INIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .RETRY_GAP_CYCLES(GAP),
        .MAX_RETRIES(MAXR),
        .CFG_MAGIC(MAGIC),
        .DEFAULT_NODE_ID(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_reload(i_reload),
        .i_eeprom_busy(i_eeprom_busy),
        .i_eeprom_done(i_eeprom_done),
        .i_page(i_page),
        .o_eeprom_start(o_eeprom_start),
        .o_node_id(o_node_id),
        .o_cfg_flags(o_cfg_flags),
        .o_cfg_valid(o_cfg_valid),
        .o_cfg_error(o_cfg_error),
        .o_loading(o_loading),
        .o_attempt(o_attempt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Pin driver: busy window, scheduled done pulses, random page noise when not done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_eeprom_busy = (cyc < busy_hi);
            if (cyc == done_at) begin
                i_eeprom_done = 1'b1;
                i_page        = done_page;
            end else if (cyc == spur_at) begin
                i_eeprom_done = 1'b1;
                i_page        = spur_page;
            end else begin
                i_eeprom_done = 1'b0;
                i_page        = {$urandom, $urandom};
            end
        end
    end

    // EEPROM responder and event monitor, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_start = 1'b0;
            end else begin
                if (o_eeprom_start) begin
                    if (prev_start) consec_err++;
                    start_q.push_back(cyc);
                    mon_idx = att_idx;
                    att_idx++;
                    if (mon_idx < 4 && cur_delay[mon_idx] != 8'd0) begin
                        done_at   = cyc + int'(cur_delay[mon_idx]);
                        done_page = cur_page[mon_idx];
                    end else begin
                        done_at = -1;
                    end
                end
                prev_start = o_eeprom_start;
                if (o_cfg_valid && first_valid < 0) first_valid = cyc;
                if (o_cfg_error && first_err < 0) first_err = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycle(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic do_reset(output int r);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        i_reload    = 1'b0;
        done_at     = -1;
        spur_at     = -1;
        att_idx     = 0;
        start_q.delete();
        first_valid = -1;
        first_err   = -1;
        consec_err  = 0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        r     = cyc;
    endtask

    function automatic logic [63:0] make_page(input bit good);
        logic [7:0] b[8];
        logic [7:0] x;
        logic [63:0] p;
        int k;
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        b[6] = MAGIC;
        if (!good && $urandom_range(0, 1) == 1) b[6] = MAGIC ^ 8'($urandom_range(1, 255));
        x = 8'h00;
        for (int i = 0; i < 7; i++) x = x ^ b[i];
        b[7] = x;
        if (!good && b[6] == MAGIC) begin
            k = $urandom_range(0, 7);
            b[k] = b[k] ^ 8'(1 << $urandom_range(0, 7));
        end
        for (int i = 0; i < 8; i++) p[8*i +: 8] = b[i];
        return p;
    endfunction

    function automatic logic [7:0] rand_delay();
        int k;
        k = $urandom_range(0, 9);
        if (k <= 1) return 8'd0;
        if (k == 2) return 8'(TIMEOUT);
        if (k == 3) return 8'd1;
        return 8'($urandom_range(1, TIMEOUT));
    endfunction

    function automatic vec_t make_vec(input int hold, input int d0, input int d1, input int d2,
                                      input logic [63:0] p0, input logic [63:0] p1,
                                      input logic [63:0] p2, input logic [3:0] good,
                                      input int first_off, input int nstarts,
                                      input logic [7:0] node, input logic [7:0] flags,
                                      input logic valid, input logic err, input logic [3:0] att);
        vec_t v;
        v.busy_hold     = hold;
        v.delay         = '0;
        v.pages         = '0;
        v.delay[0]      = 8'(d0);
        v.delay[1]      = 8'(d1);
        v.delay[2]      = 8'(d2);
        v.pages[0]      = p0;
        v.pages[1]      = p1;
        v.pages[2]      = p2;
        v.good          = good;
        v.hand          = 1'b1;
        v.exp_first_off = first_off;
        v.exp_nstarts   = nstarts;
        v.exp_node      = node;
        v.exp_flags     = flags;
        v.exp_valid     = valid;
        v.exp_error     = err;
        v.exp_attempt   = att;
        return v;
    endfunction

    // Event-level model: each attempt starts when both the earliest-allowed cycle and busy permit,
    // ends on its accepted response or on timeout, and retries after the idle gap.
    task automatic model_run(input int r, input vec_t v);
        int t, s, d, fail_c, att;
        bit fin;
        m_starts.delete();
        m_valid_cyc = -1;
        m_err_cyc   = -1;
        att = 0;
        fin = 1'b0;
        t   = r + INIT;
        while (!fin) begin
            s = (t < r + INIT + v.busy_hold) ? r + INIT + v.busy_hold : t;
            m_starts.push_back(s);
            att++;
            d = int'(v.delay[att-1]);
            if (d >= 1 && d <= TIMEOUT && v.good[att-1]) begin
                m_valid_cyc = s + d + 2;
                m_node  = v.pages[att-1][7:0];
                m_flags = v.pages[att-1][15:8];
                m_valid = 1'b1;
                m_err   = 1'b0;
                fin     = 1'b1;
            end else begin
                fail_c = (d >= 1 && d <= TIMEOUT) ? s + d + 1 : s + TIMEOUT;
                if (att > MAXR) begin
                    m_err_cyc = fail_c + 1;
                    m_node  = 8'h00;
                    m_flags = 8'h00;
                    m_valid = 1'b0;
                    m_err   = 1'b1;
                    fin     = 1'b1;
                end else begin
                    t = fail_c + GAP + 1;
                end
            end
        end
        m_attempt = att;
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        int r, n, lim;
        cur_delay = v.delay;
        cur_page  = v.pages;
        do_reset(r);
        busy_hi = r + INIT + v.busy_hold;
        model_run(r, v);
        @(negedge clk);
        check_output($sformatf("%s rst node", tag), o_node_id, 8'h00);
        check_output($sformatf("%s rst flags", tag), o_cfg_flags, 8'h00);
        check_output($sformatf("%s rst valid", tag), o_cfg_valid, 1'b0);
        check_output($sformatf("%s rst error", tag), o_cfg_error, 1'b0);
        check_output($sformatf("%s rst attempt", tag), o_attempt, 4'd0);
        check_output($sformatf("%s rst loading", tag), o_loading, 1'b0);
        check_output($sformatf("%s rst start", tag), o_eeprom_start, 1'b0);
        n = 0;
        while (!((o_cfg_valid || o_cfg_error) && !o_loading) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_output($sformatf("%s settled", tag), n < 1000, 1'b1);
        @(negedge clk);
        check_output($sformatf("%s nstarts", tag), start_q.size(), m_starts.size());
        lim = (start_q.size() < m_starts.size()) ? start_q.size() : m_starts.size();
        for (int i = 0; i < lim; i++) begin
            check_output($sformatf("%s start%0d cycle", tag, i), start_q[i] - r, m_starts[i] - r);
        end
        check_output($sformatf("%s valid cycle", tag), first_valid, m_valid_cyc);
        check_output($sformatf("%s error cycle", tag), first_err, m_err_cyc);
        check_output($sformatf("%s node", tag), o_node_id, m_node);
        check_output($sformatf("%s flags", tag), o_cfg_flags, m_flags);
        check_output($sformatf("%s valid", tag), o_cfg_valid, m_valid);
        check_output($sformatf("%s error", tag), o_cfg_error, m_err);
        check_output($sformatf("%s attempt", tag), o_attempt, 4'(m_attempt));
        check_output($sformatf("%s back to back start", tag), consec_err, 0);
        if (v.hand) begin
            check_output($sformatf("%s hand first start", tag),
                         (start_q.size() > 0) ? start_q[0] - r : -1, v.exp_first_off);
            check_output($sformatf("%s hand nstarts", tag), start_q.size(), v.exp_nstarts);
            check_output($sformatf("%s hand node", tag), o_node_id, v.exp_node);
            check_output($sformatf("%s hand flags", tag), o_cfg_flags, v.exp_flags);
            check_output($sformatf("%s hand valid", tag), o_cfg_valid, v.exp_valid);
            check_output($sformatf("%s hand error", tag), o_cfg_error, v.exp_error);
            check_output($sformatf("%s hand attempt", tag), o_attempt, v.exp_attempt);
        end
    endtask

    task automatic reload_sequence();
        int c;
        apply_stimulus(vecs[0], "reload_pre");
        cur_delay    = '0;
        cur_delay[0] = 8'd20;
        cur_page[0]  = PAGE_22;
        @(posedge clk);
        #1;
        c        = cyc;
        i_reload = 1'b1;
        att_idx  = 0;
        start_q.delete();
        @(posedge clk);
        #1;
        i_reload = 1'b0;
        @(negedge clk);
        first_valid = -1;
        check_output("reload valid drop", o_cfg_valid, 1'b0);
        check_output("reload node hold", o_node_id, 8'h17);
        check_output("reload flags hold", o_cfg_flags, 8'h03);
        check_output("reload attempt clr", o_attempt, 4'd0);
        check_output("reload loading", o_loading, 1'b1);
        check_output("reload start", o_eeprom_start, 1'b1);
        wait_cycle(c + 5);
        @(posedge clk);
        #1;
        i_reload = 1'b1;
        @(posedge clk);
        #1;
        i_reload = 1'b0;
        wait_cycle(c + 22);
        check_output("reload pre-update valid", o_cfg_valid, 1'b0);
        check_output("reload pre-update node", o_node_id, 8'h17);
        check_output("reload pre-update attempt", o_attempt, 4'd1);
        wait_cycle(c + 23);
        check_output("reload new valid", o_cfg_valid, 1'b1);
        check_output("reload new node", o_node_id, 8'h22);
        check_output("reload new attempt", o_attempt, 4'd1);
        @(negedge clk);
        check_output("reload nstarts", start_q.size(), 1);
        check_output("reload valid cycle", first_valid - c, 23);
    endtask

    task automatic fail_reload_sequence();
        apply_stimulus(vecs[1], "failreload_pre");
        cur_delay = '0;
        @(posedge clk);
        #1;
        i_reload = 1'b1;
        @(posedge clk);
        #1;
        i_reload = 1'b0;
        @(negedge clk);
        check_output("failreload error clr", o_cfg_error, 1'b0);
        check_output("failreload attempt clr", o_attempt, 4'd0);
        check_output("failreload valid", o_cfg_valid, 1'b0);
        check_output("failreload loading", o_loading, 1'b1);
        check_output("failreload node", o_node_id, 8'h00);
    endtask

    task automatic midreset_sequence();
        int c, r2;
        apply_stimulus(vecs[0], "midrst_pre");
        cur_delay = '0;
        att_idx   = 0;
        start_q.delete();
        @(posedge clk);
        #1;
        c        = cyc;
        i_reload = 1'b1;
        @(posedge clk);
        #1;
        i_reload = 1'b0;
        wait_cycle(c + 6);
        check_output("midrst in wait loading", o_loading, 1'b1);
        check_output("midrst in wait attempt", o_attempt, 4'd1);
        check_output("midrst in wait node", o_node_id, 8'h17);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        spur_at      = cyc + 4;
        spur_page    = PAGE_22;
        cur_delay[0] = 8'd20;
        cur_page[0]  = PAGE_GOOD;
        done_at      = -1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        r2    = cyc;
        att_idx = 0;
        start_q.delete();
        first_valid = -1;
        @(negedge clk);
        check_output("midrst node", o_node_id, 8'h00);
        check_output("midrst flags", o_cfg_flags, 8'h00);
        check_output("midrst valid", o_cfg_valid, 1'b0);
        check_output("midrst error", o_cfg_error, 1'b0);
        check_output("midrst attempt", o_attempt, 4'd0);
        check_output("midrst loading", o_loading, 1'b0);
        check_output("midrst start", o_eeprom_start, 1'b0);
        wait_cycle(r2 + 9);
        check_output("midrst init hold start", o_eeprom_start, 1'b0);
        check_output("midrst init hold loading", o_loading, 1'b0);
        wait_cycle(r2 + 10);
        check_output("midrst restart start", o_eeprom_start, 1'b1);
        wait_cycle(r2 + 31);
        check_output("midrst pre valid", o_cfg_valid, 1'b0);
        wait_cycle(r2 + 32);
        check_output("midrst final valid", o_cfg_valid, 1'b1);
        check_output("midrst final node", o_node_id, 8'h17);
        check_output("midrst final flags", o_cfg_flags, 8'h03);
        check_output("midrst final attempt", o_attempt, 4'd1);
    endtask

    initial begin
        vec_t rv;
        checks = 0;
        errors = 0;
        cyc = 0;
        busy_hi = 0;
        done_at = -1;
        spur_at = -1;
        done_page = '0;
        spur_page = '0;
        cur_delay = '0;
        cur_page = '0;
        att_idx = 0;
        mon_idx = 0;
        first_valid = -1;
        first_err = -1;
        consec_err = 0;
        prev_start = 1'b0;
        reset = 1'b1;
        i_reload = 1'b0;
        i_eeprom_busy = 1'b1;
        i_eeprom_done = 1'b0;
        i_page = '0;

        vecs[0] = make_vec(0, 20, 0, 0, PAGE_GOOD, '0, '0, 4'b0001,
                           10, 1, 8'h17, 8'h03, 1'b1, 1'b0, 4'd1);
        vecs[1] = make_vec(0, 20, 20, 20, PAGE_BADSUM, PAGE_BADSUM, PAGE_BADSUM, 4'b0000,
                           10, 3, 8'h00, 8'h00, 1'b0, 1'b1, 4'd3);
        vecs[2] = make_vec(0, 0, 20, 0, PAGE_22, PAGE_GOOD, '0, 4'b0010,
                           10, 2, 8'h17, 8'h03, 1'b1, 1'b0, 4'd2);
        vecs[3] = make_vec(30, 20, 0, 0, PAGE_GOOD, '0, '0, 4'b0001,
                           40, 1, 8'h17, 8'h03, 1'b1, 1'b0, 4'd1);
        vecs[4] = make_vec(0, TIMEOUT, 0, 0, PAGE_22, '0, '0, 4'b0001,
                           10, 1, 8'h22, 8'h03, 1'b1, 1'b0, 4'd1);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            rv.busy_hold = $urandom_range(0, 12);
            rv.delay = '0;
            rv.pages = '0;
            for (int k = 0; k < 4; k++) begin
                rv.good[k]  = ($urandom_range(0, 2) != 0);
                rv.delay[k] = rand_delay();
                rv.pages[k] = make_page(rv.good[k]);
            end
            rv.hand = 1'b0;
            rv.exp_first_off = 0;
            rv.exp_nstarts = 0;
            rv.exp_node = 8'h00;
            rv.exp_flags = 8'h00;
            rv.exp_valid = 1'b0;
            rv.exp_error = 1'b0;
            rv.exp_attempt = 4'd0;
            apply_stimulus(rv, $sformatf("rand%0d", i));
        end

        reload_sequence();
        fail_reload_sequence();
        midreset_sequence();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
